// File: rtl/dc_router_fifo.sv
// Synchronous FIFO between the router and the FFT/FIR accelerator.
// Registered read data and flags, sticky overflow/underflow, sync flush.
module dc_router_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  put_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  get_req,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dv_q;
    logic                  full_q;
    logic                  empty_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  do_put;
    logic                  do_get;

    assign do_put = put_req & ~full_q;
    assign do_get = get_req & ~empty_q;

    always_comb begin
        cnt_nxt = cnt_q;
        case ({do_put, do_get})
            2'b10:   cnt_nxt = cnt_q + 1'b1;
            2'b01:   cnt_nxt = cnt_q - 1'b1;
            default: cnt_nxt = cnt_q;
        endcase
    end

    // Storage is never reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && !clear && do_put)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (do_put)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_get) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= mem[rd_ptr];
            end
            dv_q    <= do_get;
            cnt_q   <= cnt_nxt;
            full_q  <= (cnt_nxt == FULL_CNT);
            empty_q <= (cnt_nxt == '0);
            if (put_req && full_q)
                ovf_q <= 1'b1;
            if (get_req && empty_q)
                unf_q <= 1'b1;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = cnt_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_dc_router_fifo.sv
// Bench for dc_router_fifo: queue-based model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dc_router_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          put_req = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          get_req = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    dc_router_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .ADDR_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .put_req(put_req),
        .data_in(data_in),
        .get_req(get_req),
        .clear(clear),
        .data_out(data_out),
        .data_valid(data_valid),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of words plus the flag/output registers.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_do = '0;
    logic          m_dv = 1'b0;
    logic          m_ov = 1'b0;
    logic          m_un = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_do = '0;
            m_dv = 1'b0;
            m_ov = 1'b0;
            m_un = 1'b0;
        end else if (clear) begin
            q.delete();
            m_dv = 1'b0;
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            automatic bit pa = put_req && (q.size() < DEPTH);
            automatic bit ga = get_req && (q.size() > 0);
            if (put_req && !pa) m_ov = 1'b1;
            if (get_req && !ga) m_un = 1'b1;
            m_dv = ga;
            if (ga) m_do = q.pop_front();
            if (pa) q.push_back(data_in);
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.data_out", data_out, m_do);
        chk("m.data_valid", 32'(data_valid), 32'(m_dv));
        chk("m.count", 32'(count), q.size());
        chk("m.full", 32'(full), 32'(q.size() == DEPTH));
        chk("m.empty", 32'(empty), 32'(q.size() == 0));
        chk("m.overflow", 32'(overflow), 32'(m_ov));
        chk("m.underflow", 32'(underflow), 32'(m_un));
    end

    task automatic step(input logic p, input logic [DW-1:0] d,
                        input logic g, input logic c);
        put_req = p;
        data_in = d;
        get_req = g;
        clear   = c;
        @(negedge clk);
        #1;
        put_req = 1'b0;
        get_req = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".do"}, data_out, 0);
        chk({tag, ".dv"}, 32'(data_valid), 0);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".count"}, 32'(count), 0);
        chk({tag, ".ovf"}, 32'(overflow), 0);
        chk({tag, ".unf"}, 32'(underflow), 0);
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b1;

        // Fill to full, then one rejected put.
        for (int i = 1; i <= 16; i++)
            step(1'b1, DW'(i), 1'b0, 1'b0);
        chk("fill.count", 32'(count), 16);
        chk("fill.full", 32'(full), 1);
        step(1'b1, 99, 1'b0, 1'b0);
        chk("ovf.flag", 32'(overflow), 1);
        chk("ovf.full", 32'(full), 1);
        chk("ovf.count", 32'(count), 16);

        // Drain in order, then one rejected get.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain.do", data_out, i);
            chk("drain.dv", 32'(data_valid), 1);
        end
        chk("drain.empty", 32'(empty), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("unf.flag", 32'(underflow), 1);
        chk("unf.dv", 32'(data_valid), 0);
        chk("unf.do", data_out, 16);

        // Advance pointers to 10, then wrap across 15->0.
        for (int i = 0; i < 10; i++)
            step(1'b1, DW'(200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("p10.do", data_out, 200 + i);
        end
        for (int i = 0; i < 12; i++)
            step(1'b1, DW'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("wrap.do", data_out, 100 + i);
            chk("wrap.dv", 32'(data_valid), 1);
        end
        chk("wrap.count", 32'(count), 0);

        // Simultaneous put/get at count 5, 0 and 16.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, DW'(300 + i), 1'b0, 1'b0);
        step(1'b1, 305, 1'b1, 1'b0);
        chk("pg5.count", 32'(count), 5);
        chk("pg5.do", data_out, 300);
        for (int i = 0; i < 5; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        chk("pg5.drain", data_out, 305);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 400, 1'b1, 1'b0);
        chk("pg0.count", 32'(count), 1);
        chk("pg0.unf", 32'(underflow), 1);
        chk("pg0.dv", 32'(data_valid), 0);
        for (int i = 1; i < 16; i++)
            step(1'b1, DW'(400 + i), 1'b0, 1'b0);
        chk("pg16.pre", 32'(count), 16);
        step(1'b1, 500, 1'b1, 1'b0);
        chk("pg16.count", 32'(count), 15);
        chk("pg16.ovf", 32'(overflow), 1);
        chk("pg16.do", data_out, 400);

        // Clear beats a put at count 7 with overflow set.
        for (int i = 0; i < 8; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        chk("clr.pre", 32'(count), 7);
        step(1'b1, 77, 1'b0, 1'b1);
        chk("clr.count", 32'(count), 0);
        chk("clr.empty", 32'(empty), 1);
        chk("clr.ovf", 32'(overflow), 0);
        chk("clr.do", data_out, 408);

        // Asynchronous reset between edges at count 9.
        for (int i = 0; i < 9; i++)
            step(1'b1, DW'(600 + i), 1'b0, 1'b0);
        chk("ar.pre", 32'(count), 9);
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("ar");
        put_req = 1'b1;
        data_in = 33;
        @(negedge clk);
        #1;
        put_req = 1'b0;
        chk("ar.ignore", 32'(count), 0);
        reset = 1'b1;
        step(1'b1, 5, 1'b0, 1'b0);
        chk("ar.put", 32'(count), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ar.get.do", data_out, 5);
        chk("ar.get.dv", 32'(data_valid), 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dc_router_fifo.md
DC_ROUTER_FIFO -- requirements
Module: dc_router_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width of the data path between the router and the FFT/FIR accelerator.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of entries, a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4: log2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port put_req, input, 1 bit: write request from the router (fft_put_req or fir_put_req).
REQ-007 The block SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-008 The block SHALL have port get_req, input, 1 bit: read request from the consumer.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous flush.
REQ-010 The block SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-011 The block SHALL have port data_valid, output, 1 bit: data_out carries a newly read word this cycle.
REQ-012 The block SHALL have port full, output, 1 bit: high when count equals DEPTH; this is the router's to_*_full / from_*_full.
REQ-013 The block SHALL have port empty, output, 1 bit: high when count is 0; this is the router's to_*_empty / from_*_empty.
REQ-014 The block SHALL have port count, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, a put was attempted while full.
REQ-016 The block SHALL have port underflow, output, 1 bit: sticky flag, a get was attempted while empty.

Function
REQ-017 A put SHALL be accepted on a rising edge when put_req=1 and full=1 is not true at the start of that cycle; data_in is then written at the write pointer, and the write pointer increments.
REQ-018 A get SHALL be accepted on a rising edge when get_req=1 and empty=0 at the start of that cycle; the word at the read pointer is registered into data_out, the read pointer increments, and data_valid=1 in the following cycle. Read latency is 1 cycle.
REQ-019 Without an accepted get, data_valid SHALL be 0 and data_out SHALL hold its last value.
REQ-020 Both pointers SHALL wrap modulo DEPTH (from DEPTH-1 to 0) without loss or reordering of data.
REQ-021 count SHALL change as follows: +1 for a put only, -1 for a get only, unchanged for both or neither.
REQ-022 full and empty SHALL be registered, decoded from the next count value, and updated on the same edge as count.
REQ-023 If put_req and get_req are both 1 while 0<count<DEPTH, the block SHALL accept both and leave count unchanged.
REQ-024 If put_req and get_req are both 1 while empty=1, the block SHALL accept only the put; count goes to 1 and underflow is set.
REQ-025 If put_req and get_req are both 1 while full=1, the block SHALL accept only the get; count goes to DEPTH-1 and overflow is set.
REQ-026 A rejected put SHALL leave storage and pointers unchanged, and set overflow to 1.
REQ-027 A rejected get SHALL leave data_out unchanged, keep data_valid at 0, and set underflow to 1.
REQ-028 overflow and underflow SHALL be cleared only by reset or clear.
REQ-029 clear=1 SHALL take priority over put_req and get_req on the same edge, with this result:
- pointers=0, count=0, empty=1, full=0;
- data_valid=0, overflow=0, underflow=0;
- data_out holds its value.
REQ-030 Storage contents SHALL not be reset or cleared; only the pointers define validity.

Reset
REQ-031 Driving reset low SHALL immediately, with no clock edge, force these values:
- data_out=0, data_valid=0;
- full=0, empty=1, count=0;
- overflow=0, underflow=0;
- both pointers=0.
REQ-032 While reset=0, the block SHALL ignore put_req, get_req and clear.
REQ-033 The first operation after reset SHALL be accepted on the first rising edge with reset=1.
REQ-034 Reset asserted mid-transfer SHALL discard all queued words.

Verification
REQ-035 Stimulus: reset, then put 1..16 on consecutive cycles, then put 99. Required response: full=1 and count=16 after the 16th edge; 99 not stored; overflow=1; full stays 1.
REQ-036 Stimulus: get 16 times from full, then get once more. Required response: data_out=1..16 in order, each with data_valid=1 one cycle after its get; empty=1 after the 16th; the 17th get gives underflow=1, data_valid=0, and data_out stays 16.
REQ-037 Stimulus: put 10 and get 10, then put 100..111 and get 12. Required response: output is 100..111 in order across the pointer wrap 15->0; count returns to 0.
REQ-038 Stimulus: simultaneous put/get at count=5, at count=0, and at count=16. Required response, respectively:
- count stays 5;
- count=1 with underflow=1;
- count=15 with overflow=1.
REQ-039 Stimulus: at count=7 with overflow=1, assert clear together with put_req. Required response: count=0, empty=1, overflow=0, and the put is ignored.
REQ-040 Stimulus: at count=9, drive reset low midway between edges. Required response: outputs take their REQ-031 values before the next edge; after release, a put of 5 then a get returns 5.
